load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core memory request at a time, performs aligned loads,
// word stores and read-modify-write sub-word stores against a single-port data memory.
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   // Out-of-range word indices are passed through; the depth only has to be meaningful.
   if (MEM_WORDS == 0) begin : g_bad_depth
      $error("load_store_unit: MEM_WORDS must be nonzero");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_state_n;

   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        r_req_ready;
   logic        r_busy;
   logic        r_mem_rd_en;
   logic        r_mem_wr_en;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;

   logic        w_accept;
   logic        w_illegal;
   logic        w_rmw;
   logic        w_we_cur;
   logic [31:0] w_addr_cur;
   logic [31:0] w_wdata_cur;

   function automatic logic f_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic bad;
      case (f3)
         3'b000:  bad = 1'b0;
         3'b001:  bad = a[0];
         3'b010:  bad = (a != 2'b00);
         3'b100:  bad = we;
         3'b101:  bad = we | a[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Replace the addressed byte (f3[0]=0) or halfword (f3[0]=1) lane of the old word.
   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [2:0] f3,
                                           input logic [1:0] a, input logic [31:0] wd);
      logic [31:0] base;
      logic [4:0]  sh;
      base = f3[0] ? 32'h0000_FFFF : 32'h0000_00FF;
      sh   = f3[0] ? 5'({a[1], 4'b0000}) : 5'({a, 3'b000});
      return (old & ~(base << sh)) | ((wd & base) << sh);
   endfunction

   function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] a);
      logic [31:0] sw;
      logic [31:0] res;
      sw = word >> 5'({a, 3'b000});
      case (f3)
         3'b000:  res = {{24{sw[7]}}, sw[7:0]};
         3'b001:  res = {{16{sw[15]}}, sw[15:0]};
         3'b100:  res = {24'h0, sw[7:0]};
         3'b101:  res = {16'h0, sw[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   assign w_accept    = req_valid && r_req_ready;
   assign w_illegal   = f_illegal(req_we, req_funct3, req_addr[1:0]);
   assign w_rmw       = req_we && (req_funct3[2:1] == 2'b00);
   assign w_we_cur    = w_accept ? req_we    : r_we;
   assign w_addr_cur  = w_accept ? req_addr  : r_addr;
   assign w_wdata_cur = w_accept ? req_wdata : r_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_illegal)  w_state_n = S_RESP;
               else if (w_rmw) w_state_n = S_RMW_RD;
               else            w_state_n = S_ACCESS;
            end
         end
         S_ACCESS: w_state_n = S_RESP;
         S_RMW_RD: w_state_n = S_RMW_WR;
         S_RMW_WR: w_state_n = S_RESP;
         S_RESP:   w_state_n = S_IDLE;
         default:  w_state_n = S_IDLE;
      endcase
   end

   // Request capture; inputs are ignored after the accept edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
      end else if (w_accept) begin
         r_we     <= req_we;
         r_funct3 <= req_funct3;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
      end
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_mem_rd_en  <= 1'b0;
         r_mem_wr_en  <= 1'b0;
         r_mem_addr   <= 32'h0;
         r_mem_wdata  <= 32'h0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
      end else begin
         r_req_ready  <= (w_state_n == S_IDLE);
         r_busy       <= (w_state_n != S_IDLE);
         r_mem_rd_en  <= ((w_state_n == S_ACCESS) && !w_we_cur) || (w_state_n == S_RMW_RD);
         r_mem_wr_en  <= ((w_state_n == S_ACCESS) && w_we_cur) || (w_state_n == S_RMW_WR);
         r_mem_addr   <= {2'b00, w_addr_cur[31:2]};
         r_resp_valid <= (w_state_n == S_RESP);
         if (w_state_n == S_ACCESS) begin
            r_mem_wdata <= w_wdata_cur;
         end else if (w_state_n == S_RMW_WR) begin
            r_mem_wdata <= f_merge(mem_rdata, r_funct3, r_addr[1:0], r_wdata);
         end
         if (w_state_n == S_RESP) begin
            if (r_state == S_IDLE) begin
               r_resp_err   <= 1'b1;
               r_resp_rdata <= 32'h0;
            end else if ((r_state == S_ACCESS) && !r_we) begin
               r_resp_err   <= 1'b0;
               r_resp_rdata <= f_extend(mem_rdata, r_funct3, r_addr[1:0]);
            end else begin
               r_resp_err   <= 1'b0;
               r_resp_rdata <= 32'h0;
            end
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign busy       = r_busy;
   assign mem_rd_en  = r_mem_rd_en;
   assign mem_wr_en  = r_mem_wr_en;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule
